// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (CPU side) and mem_responder.
//   req_*  : valid/ready request channel (write flag, word address, write data)
//   rsp_*  : valid/ready response channel (write-ack flag, read data)
// master drives requests and takes responses; slave is the memory side.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [0:ADDR_W-1] req_addr;
  logic [0:DATA_W-1] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [0:DATA_W-1] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 2**ADDR_W x DATA_W storage serving one outstanding
// request at a time. Reads respond READ_LAT cycles after acceptance, writes
// are acknowledged one cycle after acceptance. A loader port writes storage
// in any state and blocks request acceptance while active in IDLE.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   bus             request/response channels (slave modport)
//   load_en/addr/data  loader write port
//   rd_count, wr_count saturating counts of accepted bus reads / writes
module mem_responder #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 2   // legal 1..4
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  input  logic              load_en,
  input  logic [0:ADDR_W-1] load_addr,
  input  logic [0:DATA_W-1] load_data,
  output logic [0:15]       rd_count,
  output logic [0:15]       wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [0:15] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic [0:DATA_W-1] mem [DEPTH];

  assign accept_c = bus.req_valid & bus.req_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the WAIT counter leaves for RESP on the edge it would hit 0,
  // so rsp_valid is first seen exactly READ_LAT cycles after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.req_write || READ_LAT == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(READ_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.req_ready = rst & ~load_en;
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Response payload captured at acceptance and held until the next one;
  // the read snapshot makes later writes/loads invisible to this response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= '0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else if (accept_c) begin
      if (bus.req_write) begin
        bus.rsp_write <= 1'b1;
        bus.rsp_rdata <= '0;
        if (wr_count != CNT_MAX) wr_count <= wr_count + 16'd1;
      end else begin
        bus.rsp_write <= 1'b0;
        bus.rsp_rdata <= mem[bus.req_addr];
        if (rd_count != CNT_MAX) rd_count <= rd_count + 16'd1;
      end
    end
  end

  // Storage; not reset. Loader and bus write never coincide because a load
  // blocks acceptance.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (accept_c && bus.req_write) begin
      mem[bus.req_addr] <= bus.req_wdata;
    end
  end

endmodule
